mips_state_dump: RTL and testbench
==================================

# mips_state_dump

Synthesizable end-of-run state capture engine for the single-cycle MIPS core. It watches the program counter for a halt (self-loop) or a cycle timeout, freezes the core, then walks the register file and a configurable data-memory window. Every value leaves as a tagged record on a valid/ready stream, feeding a UART or trace FIFO on hardware and a checker in simulation. Replaces time-delay-then-print dumping with cycle-exact, back-pressurable readout.

## Interface
- DATA_W, 32, register/memory word width
- ADDR_W, 32, PC and data-memory byte-address width
- NUM_REGS, 32, registers dumped (indices 0..NUM_REGS-1); REG_IDX_W = $clog2(NUM_REGS)
- MEM_BASE, 0, first dumped byte address (word aligned)
- MEM_WORDS, 12, data-memory words dumped at MEM_BASE+4*k
- STALL_LIMIT, 8, consecutive cycles of unchanged PC that declare halt (>=2)
- TIMEOUT, 1000000, run-cycle limit; CNT_W = $clog2(TIMEOUT+1)
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level; arms the monitor, must stay high until done
- pc  in  ADDR_W  core program counter
- cpu_freeze  out  1  stalls core PC/register/memory writes
- rf_rd_idx  out  REG_IDX_W  register-file debug read index
- rf_rd_data  in  DATA_W  register data, valid one cycle after index
- dm_rd_addr  out  ADDR_W  data-memory debug byte address (word assembled big-endian by memory)
- dm_rd_data  in  DATA_W  memory word, valid one cycle after address
- out_valid  out  1  record valid
- out_ready  in  1  sink accepts record
- out_tag  out  2  0 PC, 1 REG, 2 MEM, 3 END
- out_index  out  16  record index within its tag
- out_data  out  DATA_W  payload
- done  out  1  dump complete
- cause  out  1  0 stall-halt, 1 timeout

## Operation
- States: IDLE, RUN, SETTLE, EMIT_PC, RD, CAP, EMIT, EMIT_END, DONE.
- IDLE: counters cleared; start=1 -> RUN.
- RUN: cycle_cnt increments, saturating at TIMEOUT. stall_cnt increments when pc equals previous-cycle pc, else clears. Halt when stall_cnt reaches STALL_LIMIT-1 (PC held STALL_LIMIT cycles). Timeout when cycle_cnt reaches TIMEOUT. Both in same cycle -> cause=0. Either -> SETTLE; cause latched.
- SETTLE: one cycle, freeze takes effect -> EMIT_PC.
- EMIT_PC: record (0, 0, frozen pc zero-extended/truncated to DATA_W).
- RD: drive rf_rd_idx (phase REG) or dm_rd_addr (phase MEM) -> CAP; CAP registers read data into out_data -> EMIT.
- EMIT: hold record until accepted; then next register, then MEM_BASE+4*k, then EMIT_END. MEM_WORDS=0 skips MEM phase.
- EMIT_END: record (3, 0, cycle_cnt zero-extended) -> DONE.
- DONE: done=1, cause held; start=0 -> IDLE, freeze released.
- cpu_freeze=1 in every state except IDLE and RUN.
- start dropped before DONE: ignored until DONE reached.
- Total records: NUM_REGS+MEM_WORDS+2.

## Timing
- Reset (async, immediate): state IDLE; cpu_freeze, done, cause, out_valid, out_tag, out_index, out_data, rf_rd_idx, dm_rd_addr, counters all 0. Reset mid-dump aborts the stream without a final handshake.
- Halt detection latency: SETTLE entered the cycle after the STALL_LIMIT-th equal-PC cycle.
- Handshake: transfer when out_valid && out_ready at clk edge. While out_valid && !out_ready, tag/index/data held stable. out_valid never drops without transfer.
- Back-to-back records: 3 cycles per REG/MEM record with out_ready tied high (RD, CAP, EMIT); no bubble inserted before EMIT_END.
- Read port contract: data sampled in CAP, exactly one cycle after address driven in RD.
- out_index wraps modulo 2^16 (NUM_REGS, MEM_WORDS < 65536 required).

## Structure
- Package mips_dbg_pkg: tag constants (TAG_PC/REG/MEM/END), cause constants, state enum, out_index width 16.
- Sub-module mips_halt_detector: pc history register, stall_cnt, cycle_cnt, saturation, halt/timeout/cause outputs; cleared in IDLE.
- Top holds FSM, read sequencing, output register.

## Test plan
- Program ending in "j self" at PC 0x40, out_ready=1 -> after 8 stall cycles: PC record 0x40, 32 REG, 12 MEM at addresses 0..44, END; cause=0; done=1.
- Infinite non-repeating loop (PC toggles), TIMEOUT=100 -> cause=1, END data = 100.
- Random out_ready (50%) -> identical record sequence, no data change while stalled, exactly 46 transfers.
- MEM_BASE=0x100, MEM_WORDS=0, NUM_REGS=8 -> dm_rd_addr never leaves 0; 10 records.
- rst_n low during MEM phase -> out_valid, cpu_freeze, done immediately 0; restart yields full dump from PC record.
- Halt and timeout in same cycle (STALL_LIMIT=TIMEOUT edge) -> cause=0.

Source files
------------

// File: rtl/mips_dbg_pkg.sv
// Shared constants for the MIPS end-of-run state dump engine.
// Record tags, halt causes, dump FSM states and record index width.
package mips_dbg_pkg;

  localparam int IDX_W = 16;

  localparam logic [1:0] TAG_PC  = 2'd0;
  localparam logic [1:0] TAG_REG = 2'd1;
  localparam logic [1:0] TAG_MEM = 2'd2;
  localparam logic [1:0] TAG_END = 2'd3;

  localparam logic CAUSE_HALT    = 1'b0;
  localparam logic CAUSE_TIMEOUT = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_EMIT_PC,
    S_RD,
    S_CAP,
    S_EMIT,
    S_EMIT_END,
    S_DONE
  } state_t;

endpackage

// File: rtl/mips_state_dump_if.sv
// Tagged dump record stream with valid/ready handshake.
// master drives valid/tag/index/data, slave drives ready.
interface mips_state_dump_if
  import mips_dbg_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [1:0]        tag;
  logic [IDX_W-1:0]  index;
  logic [DATA_W-1:0] data;

  modport master (
    output valid, tag, index, data,
    input  ready
  );

  modport slave (
    input  valid, tag, index, data,
    output ready
  );
endinterface

// File: rtl/mips_halt_detector.sv
// PC self-loop and run-cycle timeout detector for the dump engine.
// Ports: clk, rst_n, clear, en, pc in; hit, cause, cycle_cnt out.
module mips_halt_detector
  import mips_dbg_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int STALL_LIMIT = 8,
  parameter int TIMEOUT     = 1000000,
  parameter int CNT_W       = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [ADDR_W-1:0] pc,
  output logic              hit,
  output logic              cause,
  output logic [CNT_W-1:0]  cycle_cnt
);

  localparam int ST_W = $clog2(STALL_LIMIT + 1);
  localparam logic [ST_W-1:0]  ST_LAST = ST_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] CYC_MAX = CNT_W'(TIMEOUT);

  logic [ADDR_W-1:0] prev_pc;
  logic [ST_W-1:0]   stall_cnt;
  logic [ST_W-1:0]   stall_nxt;
  logic [CNT_W-1:0]  cycle_nxt;
  logic              halt;
  logic              tout;

  // The first run cycle has no previous PC to compare with.
  always_comb begin
    cycle_nxt = cycle_cnt;
    if (cycle_cnt != CYC_MAX)
      cycle_nxt = cycle_cnt + CNT_W'(1);
    stall_nxt = '0;
    if (cycle_cnt != '0 && pc == prev_pc) begin
      stall_nxt = stall_cnt;
      if (stall_cnt != ST_LAST)
        stall_nxt = stall_cnt + ST_W'(1);
    end
    halt  = en && (stall_nxt == ST_LAST);
    tout  = en && (cycle_nxt == CYC_MAX);
    hit   = halt || tout;
    cause = halt ? CAUSE_HALT : CAUSE_TIMEOUT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_pc   <= '0;
      stall_cnt <= '0;
      cycle_cnt <= '0;
    end else if (clear) begin
      prev_pc   <= '0;
      stall_cnt <= '0;
      cycle_cnt <= '0;
    end else if (en) begin
      prev_pc   <= pc;
      stall_cnt <= stall_nxt;
      cycle_cnt <= cycle_nxt;
    end
  end

endmodule

// File: rtl/mips_state_dump.sv
// End-of-run state capture: freezes the core, streams PC/regs/mem/END.
// Ports: clk, rst_n, start, pc, debug read ports, cpu_freeze, done, cause, dump stream.
module mips_state_dump
  import mips_dbg_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 32,
  parameter int          NUM_REGS    = 32,
  parameter int unsigned MEM_BASE    = 0,
  parameter int          MEM_WORDS   = 12,
  parameter int          STALL_LIMIT = 8,
  parameter int          TIMEOUT     = 1000000,
  parameter int          REG_IDX_W   = $clog2(NUM_REGS),
  parameter int          CNT_W       = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    pc,
  output logic                 cpu_freeze,
  output logic [REG_IDX_W-1:0] rf_rd_idx,
  input  logic [DATA_W-1:0]    rf_rd_data,
  output logic [ADDR_W-1:0]    dm_rd_addr,
  input  logic [DATA_W-1:0]    dm_rd_data,
  output logic                 done,
  output logic                 cause,
  mips_state_dump_if.master    dump
);

  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM =
    IDX_W'((MEM_WORDS == 0) ? 0 : MEM_WORDS - 1);

  state_t           state;
  logic             mem_phase;
  logic             hit;
  logic             hit_cause;
  logic [CNT_W-1:0] cycle_cnt;

  mips_halt_detector #(
    .ADDR_W      (ADDR_W),
    .STALL_LIMIT (STALL_LIMIT),
    .TIMEOUT     (TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_det (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state == S_IDLE),
    .en        (state == S_RUN),
    .pc        (pc),
    .hit       (hit),
    .cause     (hit_cause),
    .cycle_cnt (cycle_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mem_phase  <= 1'b0;
      cpu_freeze <= 1'b0;
      done       <= 1'b0;
      cause      <= 1'b0;
      rf_rd_idx  <= '0;
      dm_rd_addr <= '0;
      dump.valid <= 1'b0;
      dump.tag   <= '0;
      dump.index <= '0;
      dump.data  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          mem_phase  <= 1'b0;
          rf_rd_idx  <= '0;
          dm_rd_addr <= '0;
          if (start)
            state <= S_RUN;
        end
        S_RUN: begin
          if (hit) begin
            cause      <= hit_cause;
            cpu_freeze <= 1'b1;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          dump.valid <= 1'b1;
          dump.tag   <= TAG_PC;
          dump.index <= '0;
          dump.data  <= DATA_W'(pc);
          state      <= S_EMIT_PC;
        end
        S_EMIT_PC: begin
          if (dump.ready) begin
            dump.valid <= 1'b0;
            state      <= S_RD;
          end
        end
        S_RD: state <= S_CAP;
        S_CAP: begin
          dump.valid <= 1'b1;
          dump.tag   <= mem_phase ? TAG_MEM : TAG_REG;
          dump.data  <= mem_phase ? dm_rd_data : rf_rd_data;
          state      <= S_EMIT;
        end
        S_EMIT: begin
          if (dump.ready) begin
            if (!mem_phase && dump.index != LAST_REG) begin
              dump.valid <= 1'b0;
              dump.index <= dump.index + IDX_W'(1);
              rf_rd_idx  <= rf_rd_idx + REG_IDX_W'(1);
              state      <= S_RD;
            end else if (!mem_phase && MEM_WORDS != 0) begin
              dump.valid <= 1'b0;
              dump.index <= '0;
              mem_phase  <= 1'b1;
              dm_rd_addr <= ADDR_W'(MEM_BASE);
              state      <= S_RD;
            end else if (mem_phase && dump.index != LAST_MEM) begin
              dump.valid <= 1'b0;
              dump.index <= dump.index + IDX_W'(1);
              dm_rd_addr <= dm_rd_addr + ADDR_W'(4);
              state      <= S_RD;
            end else begin
              // valid stays high: END follows with no bubble
              dump.tag   <= TAG_END;
              dump.index <= '0;
              dump.data  <= DATA_W'(cycle_cnt);
              state      <= S_EMIT_END;
            end
          end
        end
        S_EMIT_END: begin
          if (dump.ready) begin
            dump.valid <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (!start) begin
            done       <= 1'b0;
            cpu_freeze <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_state_dump.sv
// Randomized self-checking bench for mips_state_dump (three configurations).
// Reference model derives halt cycle, cause and record list from the PC trace.
module tb_mips_state_dump;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic go = 1'b0;
  logic rdy = 1'b0;
  int   sel = 0;
  logic [31:0] pc = '0;

  logic [31:0] seq [128];
  logic [31:0] regs [32];
  logic [31:0] dmem [64];

  int nregs [3] = '{32, 8, 4};
  int mwords [3] = '{12, 0, 2};
  int mbase [3] = '{0, 'h100, 'h20};
  int slim [3] = '{8, 8, 4};
  int tlim [3] = '{100, 100, 4};

  int n_cmp = 0;
  int n_bad = 0;

  initial forever #5 clk = ~clk;

  mips_state_dump_if #(.DATA_W(32)) if_a ();
  mips_state_dump_if #(.DATA_W(32)) if_b ();
  mips_state_dump_if #(.DATA_W(32)) if_c ();

  assign if_a.ready = rdy && (sel == 0);
  assign if_b.ready = rdy && (sel == 1);
  assign if_c.ready = rdy && (sel == 2);

  logic        fr_a, fr_b, fr_c, dn_a, dn_b, dn_c, ca_a, ca_b, ca_c;
  logic [4:0]  ri_a;
  logic [2:0]  ri_b;
  logic [1:0]  ri_c;
  logic [31:0] da_a, da_b, da_c;
  logic [31:0] rd_a, rd_b, rd_c, md_a, md_b, md_c;

  mips_state_dump #(
    .NUM_REGS(32), .MEM_BASE(0), .MEM_WORDS(12),
    .STALL_LIMIT(8), .TIMEOUT(100)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(go && sel == 0), .pc(pc),
    .cpu_freeze(fr_a), .rf_rd_idx(ri_a), .rf_rd_data(rd_a),
    .dm_rd_addr(da_a), .dm_rd_data(md_a),
    .done(dn_a), .cause(ca_a), .dump(if_a)
  );

  mips_state_dump #(
    .NUM_REGS(8), .MEM_BASE('h100), .MEM_WORDS(0),
    .STALL_LIMIT(8), .TIMEOUT(100)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(go && sel == 1), .pc(pc),
    .cpu_freeze(fr_b), .rf_rd_idx(ri_b), .rf_rd_data(rd_b),
    .dm_rd_addr(da_b), .dm_rd_data(md_b),
    .done(dn_b), .cause(ca_b), .dump(if_b)
  );

  mips_state_dump #(
    .NUM_REGS(4), .MEM_BASE('h20), .MEM_WORDS(2),
    .STALL_LIMIT(4), .TIMEOUT(4)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .start(go && sel == 2), .pc(pc),
    .cpu_freeze(fr_c), .rf_rd_idx(ri_c), .rf_rd_data(rd_c),
    .dm_rd_addr(da_c), .dm_rd_data(md_c),
    .done(dn_c), .cause(ca_c), .dump(if_c)
  );

  // Synchronous debug read ports: data one cycle after address.
  always @(posedge clk) begin
    rd_a <= regs[ri_a];
    rd_b <= regs[ri_b];
    rd_c <= regs[ri_c];
    md_a <= dmem[da_a[7:2]];
    md_b <= dmem[da_b[7:2]];
    md_c <= dmem[da_c[7:2]];
  end

  logic        m_valid, m_freeze, m_done, m_cause;
  logic [1:0]  m_tag;
  logic [15:0] m_index;
  logic [31:0] m_data, m_dm;

  always_comb begin
    m_valid = if_a.valid; m_tag = if_a.tag;
    m_index = if_a.index; m_data = if_a.data;
    m_freeze = fr_a; m_done = dn_a; m_cause = ca_a; m_dm = da_a;
    if (sel == 1) begin
      m_valid = if_b.valid; m_tag = if_b.tag;
      m_index = if_b.index; m_data = if_b.data;
      m_freeze = fr_b; m_done = dn_b; m_cause = ca_b; m_dm = da_b;
    end else if (sel == 2) begin
      m_valid = if_c.valid; m_tag = if_c.tag;
      m_index = if_c.index; m_data = if_c.data;
      m_freeze = fr_c; m_done = dn_c; m_cause = ca_c; m_dm = da_c;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_data();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    for (int i = 0; i < 64; i++) dmem[i] = $urandom;
  endtask

  task automatic seq_const(input logic [31:0] v);
    for (int j = 0; j < 128; j++) seq[j] = v;
  endtask

  task automatic seq_toggle();
    seq[0] = 32'h80;
    for (int j = 1; j < 128; j++) begin
      seq[j] = seq[j-1];
      while (seq[j] == seq[j-1])
        seq[j] = 32'($urandom_range(0, 255)) << 2;
    end
  endtask

  task automatic seq_wander_hold();
    int m;
    m = $urandom_range(3, 20);
    for (int j = 0; j < 128; j++)
      seq[j] = (j <= m) ? 32'h40 + (32'($urandom_range(0, 3)) << 2)
                        : 32'h200;
  endtask

  task automatic run_dump(input int s, input bit rand_rdy,
                          input int abort_at);
    logic [49:0] expq [$];
    logic [49:0] rec, held;
    int n, run, ecause, xfers, last_x;
    bit stalled, dm_moved;
    n = 0; run = 0; ecause = 0;
    for (int j = 1; j < 128; j++) begin
      run = (j > 1 && seq[j] == seq[j-1]) ? run + 1 : 1;
      if (run >= slim[s]) begin ecause = 0; n = j; break; end
      if (j >= tlim[s]) begin ecause = 1; n = j; break; end
    end
    expq.push_back({2'd0, 16'd0, seq[n]});
    for (int i = 0; i < nregs[s]; i++)
      expq.push_back({2'd1, 16'(i), regs[i]});
    for (int k = 0; k < mwords[s]; k++)
      expq.push_back({2'd2, 16'(k), dmem[((mbase[s] >> 2) + k) % 64]});
    expq.push_back({2'd3, 16'd0, 32'(n)});

    @(negedge clk);
    sel = s; pc = seq[0]; rdy = 1'b0; go = 1'b1;
    xfers = 0; last_x = 0; stalled = 0; dm_moved = 0; held = '0;
    for (int cyc = 1; cyc < 3000 && !m_done; cyc++) begin
      @(negedge clk);
      if (!m_freeze) pc = seq[cyc < 128 ? cyc : 127];
      if (abort_at > 0 && xfers == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk("abort_outputs", {m_valid, m_freeze, m_done}, 0);
        go = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      rec = {m_tag, m_index, m_data};
      if (stalled) chk("hold_stable", {m_valid, rec}, {1'b1, held});
      if (m_dm != 0) dm_moved = 1;
      rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && rdy) begin
        if (expq.size() == 0)
          chk("extra_record", rec, '1);
        else
          chk($sformatf("rec%0d", xfers), rec, expq.pop_front());
        if (!rand_rdy && xfers > 0)
          chk("rec_spacing", cyc - last_x, (m_tag == 2'd3) ? 1 : 3);
        last_x = cyc;
        xfers++;
      end
      stalled = m_valid && !rdy;
      held = rec;
    end
    chk("done", m_done, 1);
    chk("record_count", xfers, nregs[s] + mwords[s] + 2);
    chk("cause", m_cause, ecause);
    chk("freeze_in_done", m_freeze, 1);
    if (mwords[s] == 0) chk("dm_addr_idle", dm_moved, 0);
    go = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("back_to_idle", {m_done, m_freeze, m_valid}, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk("reset_state",
           {if_a.valid, fr_a, dn_a, ca_a, if_a.tag, if_a.index,
            if_a.data, ri_a, da_a}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    fill_data();
    seq_const(32'h40);
    run_dump(0, 0, 0);

    fill_data();
    seq_toggle();
    run_dump(0, 0, 0);

    fill_data();
    seq_wander_hold();
    run_dump(0, 1, 0);

    fill_data();
    seq_wander_hold();
    run_dump(0, 0, 36);
    run_dump(0, 1, 0);

    fill_data();
    seq_wander_hold();
    run_dump(1, 1, 0);

    seq_const(32'h1c);
    run_dump(2, 0, 0);

    seq_toggle();
    run_dump(2, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
